sw_debounce_sync: RTL and testbench

SW_DEBOUNCE_SYNC -- requirements
Module: sw_debounce_sync

---
 rtl/sw_debounce_sync.sv | 101 ++++++++++
 tb/tb_sw_debounce_sync.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/sw_debounce_sync.sv
// Switch conditioner: 2-flop synchronizer, per-bit stable-count debounce,
// registered rise/fall/changed pulses. One lane instance per switch bit.

module sw_debounce_lane #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CW              = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sync_i,
    output logic out_o,
    output logic rise_o,
    output logic fall_o,
    output logic acc_o
);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_q, out_d;
    logic          rise_q, fall_q;
    logic          mism, acc;

    assign mism = (sync_i != out_q);
    assign acc  = mism && (cnt_q == CNT_MAX);

    // Any match, or the accepting edge itself, restarts the stability count.
    always_comb begin
        cnt_d = cnt_q;
        out_d = out_q;
        if (!mism || acc) cnt_d = '0;
        else              cnt_d = cnt_q + CW'(1);
        if (acc)          out_d = sync_i;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            out_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            rise_q <= acc & sync_i;
            fall_q <= acc & ~sync_i;
        end
    end

    assign out_o  = out_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;
    assign acc_o  = acc;
endmodule

module sw_debounce_sync #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] acc;
    logic             changed_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            changed_q <= 1'b0;
        end else begin
            sync1_q   <= sw_raw;
            sync2_q   <= sync1_q;
            changed_q <= |acc;
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_lane
        sw_debounce_lane #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CW             (CW)
        ) u_lane (
            .clk    (clk),
            .reset_n(reset_n),
            .sync_i (sync2_q[g]),
            .out_o  (sw_out[g]),
            .rise_o (rise[g]),
            .fall_o (fall[g]),
            .acc_o  (acc[g])
        );
    end

    assign changed = changed_q;
endmodule

// File: tb/tb_sw_debounce_sync.sv
// Randomized bench for sw_debounce_sync: two DUTs (DEBOUNCE_CYCLES 4 and 1)
// share one stimulus and are checked every cycle against a window-based model.

module tb_sw_debounce_sync;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] sw_raw = '0;
    logic [W-1:0] out0, rise0, fall0, out1, rise1, fall1;
    logic         ch0, ch1;

    sw_debounce_sync #(.WIDTH(W), .DEBOUNCE_CYCLES(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .sw_raw(sw_raw),
        .sw_out(out0), .rise(rise0), .fall(fall0), .changed(ch0));

    sw_debounce_sync #(.WIDTH(W), .DEBOUNCE_CYCLES(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .sw_raw(sw_raw),
        .sw_out(out1), .rise(rise1), .fall(fall1), .changed(ch1));

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model: raw values sampled at each post-reset edge. A bit accepts on
    // edge k when the twice-delayed raw level differed from the current
    // output on every one of the last DC edges since reset / last acceptance.
    logic [W-1:0] hist[$];
    logic [W-1:0] m_out[2], m_rise[2], m_fall[2];
    logic         m_ch[2];
    int           last_acc[2][W];

    function automatic int dc_of(int u);
        return (u == 0) ? 4 : 1;
    endfunction

    function automatic logic [W-1:0] dly(int k);
        return (k - 2 >= 0) ? hist[k-2] : '0;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int u = 0; u < 2; u++) begin
            m_out[u] = '0; m_rise[u] = '0; m_fall[u] = '0; m_ch[u] = 1'b0;
            for (int i = 0; i < W; i++) last_acc[u][i] = -1;
        end
    endtask

    task automatic model_edge();
        int k;
        logic [W-1:0] nxt, d;
        bit ok;
        hist.push_back(sw_raw);
        k = hist.size() - 1;
        for (int u = 0; u < 2; u++) begin
            nxt = m_out[u];
            for (int i = 0; i < W; i++) begin
                ok = 1'b1;
                for (int j = k - dc_of(u) + 1; j <= k; j++) begin
                    if (j < 0 || j <= last_acc[u][i]) ok = 1'b0;
                    else begin
                        d = dly(j);
                        if (d[i] == m_out[u][i]) ok = 1'b0;
                    end
                end
                if (ok) begin
                    nxt[i] = ~m_out[u][i];
                    last_acc[u][i] = k;
                end
            end
            m_rise[u] = nxt & ~m_out[u];
            m_fall[u] = ~nxt & m_out[u];
            m_ch[u]   = |(m_rise[u] | m_fall[u]);
            m_out[u]  = nxt;
        end
    endtask

    task automatic check_all();
        chk("dc4_sw_out",  out0,  m_out[0]);
        chk("dc4_rise",    rise0, m_rise[0]);
        chk("dc4_fall",    fall0, m_fall[0]);
        chk("dc4_changed", ch0,   m_ch[0]);
        chk("dc4_rf_excl", rise0 & fall0, '0);
        chk("dc1_sw_out",  out1,  m_out[1]);
        chk("dc1_rise",    rise1, m_rise[1]);
        chk("dc1_fall",    fall1, m_fall[1]);
        chk("dc1_changed", ch1,   m_ch[1]);
    endtask

    // Caller is at a negedge; drive, predict the coming posedge, check after it.
    task automatic step(logic [W-1:0] raw);
        sw_raw = raw;
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic hold(logic [W-1:0] raw, int n);
        for (int c = 0; c < n; c++) step(raw);
    endtask

    // Async reset pulse away from clock edges; release at a negedge.
    task automatic do_reset(logic [W-1:0] raw_during);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_sw_out", {out1, out0}, '0);
        chk("rst_pulses", {rise1, fall1, rise0, fall0}, '0);
        chk("rst_changed", {ch1, ch0}, '0);
        sw_raw = raw_during;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [W-1:0] r, flipmask;
        bit fast;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all();
        reset_n = 1'b1;

        hold(8'h00, 20);
        hold(8'h01, 10);
        hold(8'h09, 2);
        hold(8'h01, 6);
        hold(8'h09, 10);
        hold(8'h00, 10);
        hold(8'hA5, 10);
        hold(8'hFF, 10);
        hold(8'h00, 3);
        do_reset(8'h00);
        hold(8'h00, 12);
        hold(8'h01, 10);
        hold(8'h00, 6);
        hold(8'h01, 10);
        do_reset(8'hFF);
        hold(8'hFF, 10);

        r = sw_raw;
        fast = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 31) == 0) fast = ~fast;
            flipmask = '0;
            for (int i = 0; i < W; i++)
                flipmask[i] = fast ? ($urandom_range(0, 1) == 1)
                                   : ($urandom_range(0, 15) == 0);
            r = r ^ flipmask;
            if ($urandom_range(0, 399) == 0) begin
                do_reset($urandom_range(0, 255));
                r = sw_raw;
            end
            step(r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
